// File: rtl/sorted_array_pq.sv
// Sorted-register-array min-priority queue; equal keys dequeue in arrival order.
// Define PQ_ERR_EN to add a sticky err output flagging dropped illegal requests.
module sorted_array_pq #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned KEY_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enq,
    input  logic        deq,
    input  logic [15:0] kvi,
    output logic [15:0] kvo,
    output logic        full,
    output logic        empty,
`ifdef PQ_ERR_EN
    output logic        err,
`endif
    output logic        busy
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, INS, DEL, REP} state_t;

    state_t            state, state_nxt;
    logic [15:0]       slot     [DEPTH];
    logic [15:0]       slot_nxt [DEPTH];
    logic [DEPTH-1:0]  valid, valid_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic [15:0]       kv_hold;
    logic [DEPTH-1:0]  gt;
    logic [CW-1:0]     ins_p, rep_p;
    logic              ins_found, rep_found;

    assign busy  = (state != IDLE);
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign kvo   = empty ? '0 : slot[0];

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            gt[i] = valid[i] && (slot[i][15 -: KEY_W] > kv_hold[15 -: KEY_W]);
        end
    end

    // Strict compare places a new entry behind existing equal keys.
    always_comb begin
        ins_p     = count;
        rep_p     = count;
        ins_found = 1'b0;
        rep_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (gt[i] && !ins_found) begin
                ins_p     = CW'(i);
                ins_found = 1'b1;
            end
            if (i >= 1 && gt[i] && !rep_found) begin
                rep_p     = CW'(i);
                rep_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        valid_nxt = valid;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (enq && deq)
                    state_nxt = empty ? INS : REP;
                else if (enq && !full)
                    state_nxt = INS;
                else if (deq && !empty)
                    state_nxt = DEL;
            end
            INS: begin
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    if (CW'(i) > ins_p)
                        slot_nxt[i] = slot[i-1];
                end
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == ins_p)
                        slot_nxt[i] = kv_hold;
                    valid_nxt[i] = (CW'(i) <= count);
                end
                count_nxt = count + CW'(1);
                state_nxt = IDLE;
            end
            DEL: begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    slot_nxt[i]  = slot[i+1];
                    valid_nxt[i] = valid[i+1];
                end
                slot_nxt[DEPTH-1]  = '0;
                valid_nxt[DEPTH-1] = 1'b0;
                count_nxt = count - CW'(1);
                state_nxt = IDLE;
            end
            REP: begin
                // Head drops out: entries ahead of the insertion point move down one.
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    if (CW'(i + 1) < rep_p)
                        slot_nxt[i] = slot[i+1];
                end
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CW'(i + 1) == rep_p)
                        slot_nxt[i] = kv_hold;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid   <= '0;
            count   <= '0;
            kv_hold <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) slot[i] <= '0;
        end else begin
            state <= state_nxt;
            valid <= valid_nxt;
            count <= count_nxt;
            slot  <= slot_nxt;
            if (state == IDLE)
                kv_hold <= kvi;
        end
    end

`ifdef PQ_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (state == IDLE && ((enq && !deq && full) || (deq && !enq && empty)))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sorted_array_pq.sv
// Randomized and directed bench for sorted_array_pq (DEPTH=4) against a queue-based model.
module tb_sorted_array_pq;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enq = 1'b0;
    logic        deq = 1'b0;
    logic [15:0] kvi = '0;
    logic [15:0] kvo;
    logic        full, empty, busy;
`ifdef PQ_ERR_EN
    logic        err;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] mq [$];
    logic        err_exp = 1'b0;

    sorted_array_pq #(.DEPTH(DEPTH), .KEY_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .enq   (enq),
        .deq   (deq),
        .kvi   (kvi),
        .kvo   (kvo),
        .full  (full),
        .empty (empty),
`ifdef PQ_ERR_EN
        .err   (err),
`endif
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Insert behind every entry whose key is <= the new key.
    task automatic model_insert(input logic [15:0] kv);
        int idx;
        idx = mq.size();
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i][15:8] > kv[15:8]) begin
                idx = i;
                break;
            end
        end
        mq.insert(idx, kv);
    endtask

    function automatic logic [15:0] model_head();
        return (mq.size() == 0) ? 16'h0000 : mq[0];
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_kvo"},   32'(kvo),   32'(model_head()));
        check({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
        check({tag, "_full"},  32'(full),  32'(mq.size() == DEPTH));
`ifdef PQ_ERR_EN
        check({tag, "_err"},   32'(err),   32'(err_exp));
`endif
    endtask

    task automatic op(input string tag, input logic e, input logic d, input logic [15:0] kv);
        logic        acc;
        logic [15:0] pre;
        acc = (e && d) || (e && mq.size() < DEPTH) || (d && mq.size() > 0);
        pre = model_head();
        @(negedge clk);
        enq = e; deq = d; kvi = kv;
        @(posedge clk); #1;
        enq = 1'b0; deq = 1'b0;
        check({tag, "_busy_req"}, 32'(busy), 32'(acc));
        check({tag, "_kvo_pre"},  32'(kvo),  32'(pre));
        if (e && d) begin
            if (mq.size() > 0) void'(mq.pop_front());
            model_insert(kv);
        end else if (e) begin
            if (mq.size() < DEPTH) model_insert(kv);
            else err_exp = 1'b1;
        end else if (d) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else err_exp = 1'b1;
        end
        if (acc) begin
            @(posedge clk); #1;
            check({tag, "_busy_done"}, 32'(busy), 32'd0);
        end
        check_outputs(tag);
    endtask

    task automatic drain(input string tag);
        while (mq.size() > 0) op(tag, 1'b0, 1'b1, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        err_exp = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check_outputs("rst");

        op("enq3000", 1'b1, 1'b0, 16'h3000);
        drain("drain0");

        op("enq5011", 1'b1, 1'b0, 16'h5011);
        op("enq1022", 1'b1, 1'b0, 16'h1022);
        op("enq3033", 1'b1, 1'b0, 16'h3033);
        op("enq1044", 1'b1, 1'b0, 16'h1044);
        drain("fifo_tie");

        op("fill1", 1'b1, 1'b0, 16'h1000);
        op("fill2", 1'b1, 1'b0, 16'h2000);
        op("fill3", 1'b1, 1'b0, 16'h3000);
        op("fill4", 1'b1, 1'b0, 16'h4000);
        op("enq_full", 1'b1, 1'b0, 16'h0500);
        op("rep_full", 1'b1, 1'b1, 16'h2500);
        drain("drain_full");

        do_reset();
        check_outputs("rst2");
        op("deq_empty", 1'b0, 1'b1, 16'h0);
        op("rep_empty", 1'b1, 1'b1, 16'h7000);
        drain("drain_one");

        op("rs1", 1'b1, 1'b0, 16'h2000);
        op("rs2", 1'b1, 1'b0, 16'h3000);
        op("rep_small", 1'b1, 1'b1, 16'h0100);
        drain("drain_small");

        op("ab1", 1'b1, 1'b0, 16'h4000);
        op("ab2", 1'b1, 1'b0, 16'h2000);
        @(negedge clk);
        enq = 1'b1; kvi = 16'h1000;
        @(posedge clk); #1;
        enq = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        err_exp = 1'b0;
        check("abort_busy_after", 32'(busy), 32'd0);
        check_outputs("abort");
        op("after_abort", 1'b1, 1'b0, 16'h6000);
        drain("drain_abort");

        for (int n = 0; n < 300; n++) begin
            logic [15:0] kv;
            logic        e, d;
            kv = {8'($urandom_range(0, 5) * 16), 8'($urandom)};
            e  = 1'($urandom);
            d  = 1'($urandom);
            op("rand", e, d, kv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
